// File: rtl/wb_gpio_pkg.sv
// Shared constants for the Wishbone GPIO port: register map, bus width, reset values.
package wb_gpio_pkg;

  localparam int DATA_W = 16;
  localparam int ADR_W  = 3;

  typedef enum logic [ADR_W-1:0] {
    ADR_OUT  = 3'd0,
    ADR_IN   = 3'd1,
    ADR_DIR  = 3'd2,
    ADR_IEN  = 3'd3,
    ADR_PEND = 3'd4,
    ADR_EDGE = 3'd5
  } reg_adr_e;

  localparam logic [DATA_W-1:0] RST_OUT  = '0;
  localparam logic [DATA_W-1:0] RST_DIR  = '0;
  localparam logic [DATA_W-1:0] RST_IEN  = '0;
  localparam logic [DATA_W-1:0] RST_PEND = '0;
  localparam logic [DATA_W-1:0] RST_EDGE = '0;

endpackage

// File: rtl/wb_gpio_if.sv
// Pipelined Wishbone slave bundle; clock and reset travel with the bus.
interface if_wb (
  input logic clk,
  input logic rst
);

  logic                                  cyc;
  logic                                  stb;
  logic                                  we;
  logic [wb_gpio_pkg::ADR_W-1:0]         adr;
  logic [wb_gpio_pkg::DATA_W-1:0]        dat_i;
  logic [wb_gpio_pkg::DATA_W-1:0]        dat_o;
  logic                                  ack;
  logic                                  stall;

  modport master (
    input  clk, rst, dat_o, ack, stall,
    output cyc, stb, we, adr, dat_i
  );

  modport slave (
    input  clk, rst, cyc, stb, we, adr, dat_i,
    output dat_o, ack, stall
  );

endinterface

// File: rtl/wb_gpio_sync.sv
// Per-bit pad synchroniser with rise/fall detection on the final stage.
module gpio_sync #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];
  logic [WIDTH-1:0] last;

  // NOTE: the stage array is reset too, so edge history starts from a known 0 after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
      last <= '0;
    end else begin
      stage[0] <= pins;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
      last <= stage[SYNC_STAGES-1];
    end
  end

  assign sync = stage[SYNC_STAGES-1];
  assign rise = sync & ~last;
  assign fall = ~sync & last;

endmodule

// File: rtl/wb_gpio.sv
// Wishbone GPIO: direction, synchronised inputs, edge interrupts with W1C pending bits, wait states.
module wb_gpio
  import wb_gpio_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int WAITCYCLES  = 0,
  parameter int SYNC_STAGES = 2
) (
  if_wb.slave              wb,
  output logic [WIDTH-1:0] io_out,
  output logic [WIDTH-1:0] io_oe,
  input  logic [WIDTH-1:0] io_in,
  output logic             irq
);

  logic              valid, accept, stall;
  logic [WIDTH-1:0]  out_q, dir_q, ien_q, pend_q, edge_q, pend_d;
  logic [WIDTH-1:0]  sync, rise, fall, wdata;
  logic [DATA_W-1:0] rd_data;

  assign valid    = wb.cyc & wb.stb;
  assign accept   = valid & ~stall;
  assign wdata    = wb.dat_i[WIDTH-1:0];
  assign wb.stall = stall;
  assign io_out   = out_q;
  assign io_oe    = dir_q;

  gpio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (wb.clk),
    .rst  (wb.rst),
    .pins (io_in),
    .sync (sync),
    .rise (rise),
    .fall (fall)
  );

  generate
    if (WAITCYCLES == 0) begin : g_nowait
      assign stall = 1'b0;
    end else begin : g_wait
      logic [2:0] wait_cnt;

      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      always_ff @(posedge wb.clk or posedge wb.rst) begin
        if (wb.rst) begin
          wait_cnt <= 3'(WAITCYCLES);
        end else if (valid) begin
          wait_cnt <= (wait_cnt != 3'd0) ? wait_cnt - 3'd1 : 3'(WAITCYCLES);
        end
      end

      assign stall = valid & (wait_cnt != 3'd0);
    end
  endgenerate

  // NOTE: defaults first in every always_comb so no path leaves a signal unassigned (no latches).
  always_comb begin
    rd_data = '0;
    case (wb.adr)
      ADR_OUT:  rd_data = DATA_W'(out_q);
      ADR_IN:   rd_data = DATA_W'(sync);
      ADR_DIR:  rd_data = DATA_W'(dir_q);
      ADR_IEN:  rd_data = DATA_W'(ien_q);
      ADR_PEND: rd_data = DATA_W'(pend_q);
      ADR_EDGE: rd_data = DATA_W'(edge_q);
      default:  rd_data = '0;
    endcase
  end

  // Clear is applied before set, so a same-cycle edge keeps its pending bit.
  always_comb begin
    pend_d = pend_q;
    if (accept && wb.we && (wb.adr == ADR_PEND)) pend_d = pend_q & ~wdata;
    pend_d = pend_d | (edge_q & rise) | (~edge_q & fall);
  end

  always_ff @(posedge wb.clk or posedge wb.rst) begin
    if (wb.rst) begin
      out_q  <= RST_OUT[WIDTH-1:0];
      dir_q  <= RST_DIR[WIDTH-1:0];
      ien_q  <= RST_IEN[WIDTH-1:0];
      pend_q <= RST_PEND[WIDTH-1:0];
      edge_q <= RST_EDGE[WIDTH-1:0];
    end else begin
      pend_q <= pend_d;
      if (accept && wb.we) begin
        case (wb.adr)
          ADR_OUT:  out_q  <= wdata;
          ADR_DIR:  dir_q  <= wdata;
          ADR_IEN:  ien_q  <= wdata;
          ADR_EDGE: edge_q <= wdata;
          default:  ;
        endcase
      end
    end
  end

  always_ff @(posedge wb.clk or posedge wb.rst) begin
    if (wb.rst) begin
      wb.ack   <= 1'b0;
      wb.dat_o <= '0;
      irq      <= 1'b0;
    end else begin
      wb.ack <= accept;
      irq    <= |(pend_q & ien_q);
      if (accept && !wb.we) wb.dat_o <= rd_data;
    end
  end

endmodule
